// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: clock-enable generator for a soft CPU. It offers four modes:
// free-running, divided (slow), single-step from a debounced push button,
// and halted. It also provides a heartbeat toggle and a pulse counter for display.
module cpu_step_ctrl #(
  parameter int DIV_W     = 24,
  parameter int DB_CYCLES = 250000,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode_i,
  input  logic [DIV_W-1:0] div_max_i,
  input  logic             step_btn_n_i,
  output logic             cpu_ce_o,
  output logic             heartbeat_o,
  output logic [CNT_W-1:0] ce_count_o,
  output logic [1:0]       mode_o
);

  // The debounce counter only has to reach DB_CYCLES-1. On that cycle, the
  // DB_CYCLES-th differing sample is seen and the new level is accepted.
  localparam int              DB_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  // The state encoding matches the mode_i encoding, so the state follows mode_q directly.
  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_SLOW = 2'b01,
    ST_STEP = 2'b10,
    ST_HALT = 2'b11
  } state_e;

  logic             sync1;
  logic             sync2;
  logic             db_q;
  logic [DB_W-1:0]  db_cnt;
  logic             step_req;
  logic [1:0]       mode_q;
  state_e           state;
  state_e           next_state;
  logic             state_change;
  logic [DIV_W-1:0] div_cnt;
  logic             ce_next;

  // This two-flop synchronizer takes the raw button. It idles high, which is the released level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      // NOTE: non-blocking, so sync2 takes the previous sync1 and both stages stay real flops.
      sync1 <= step_btn_n_i;
      sync2 <= sync1;
    end
  end

  // Debouncer. step_req pulses for one cycle, in the same cycle that db_q first reads 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_q     <= 1'b1;
      db_cnt   <= '0;
      step_req <= 1'b0;
    end else begin
      step_req <= 1'b0;
      if (sync2 == db_q) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_q     <= sync2;
        db_cnt   <= '0;
        step_req <= ~sync2;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  // Register the requested mode. This register is also what drives the LEDs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mode_q <= 2'b11;
    else     mode_q <= mode_i;
  end

  assign mode_o = mode_q;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_HALT;
    else     state <= next_state;
  end

  // Next-state logic. Any mode can be reached from any other, one cycle after mode_q changes.
  always_comb next_state = state_e'(mode_q);

  assign state_change = (next_state != state);

  // Output logic. During a mode transition the enable is suppressed, so a pulse
  // from the old mode cannot land inside the new one.
  always_comb begin
    // NOTE: assign the default first; then no path can leave ce_next unassigned and a latch cannot be inferred.
    ce_next = 1'b0;
    if (!state_change) begin
      case (state)
        ST_RUN:  ce_next = 1'b1;
        ST_SLOW: ce_next = (div_cnt == div_max_i);
        ST_STEP: ce_next = step_req;
        ST_HALT: ce_next = 1'b0;
      endcase
    end
  end

  // Slow-mode divider. If div_max_i drops below the current count, the counter
  // runs on to all-ones and wraps to 0 naturally, with no pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (state_change || state != ST_SLOW) begin
      div_cnt <= '0;
    end else if (div_cnt == div_max_i) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Registered clock-enable. The heartbeat and pulse counter advance on the cycle after each pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_ce_o    <= 1'b0;
      heartbeat_o <= 1'b0;
      ce_count_o  <= '0;
    end else begin
      cpu_ce_o <= ce_next;
      if (cpu_ce_o) begin
        heartbeat_o <= ~heartbeat_o;
        ce_count_o  <= ce_count_o + CNT_W'(1);
      end
    end
  end

endmodule
